dl_reg_rr_arb: RTL and testbench
================================

Name: dl_reg_rr_arb

Overview:
- Round-robin write arbiter and storage for one shared synchronous-reset register.
- NUM_REQ requesters compete for the single write port; one winner per cycle; the winner's data is captured into q at the next clock edge.
- Optional per-requester lock lets the current owner keep the port for a burst of up to MAX_HOLD consecutive grants.
- Used wherever several pipeline agents update one architectural/status register (e.g. CSR-style shared state).

Parameters:
- NUM_REQ, 4, number of requesters; legal range >= 2.
- NUM_BITS, 32, register/data width.
- RST_VAL, 0, value of q after reset.
- MAX_HOLD, 4, maximum consecutive grants in one locked burst; legal range >= 1.
- IDX_W (derived), $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- req  in  NUM_REQ  per-requester write request.
- lock  in  NUM_REQ  per-requester burst-hold request; ignored unless the matching req bit is 1.
- wdata  in  NUM_REQ*NUM_BITS  packed write data; requester i occupies bits [i*NUM_BITS +: NUM_BITS].
- gnt  out  NUM_REQ  one-hot or zero grant, combinational from state and req.
- q  out  NUM_BITS  registered shared register value.
- q_upd  out  1  registered pulse: q was written at the last edge.
- q_src  out  IDX_W  registered index of the requester that last wrote q.

Behaviour:
- Internal state:
  - ptr: IDX_W, round-robin start index.
  - locked: 1 bit.
  - owner: IDX_W.
  - hold_cnt: width holds 0..MAX_HOLD.
- Reset (rst_n=0 at an edge): q=RST_VAL, q_upd=0, q_src=0, ptr=0, locked=0, owner=0, hold_cnt=0.
  - gnt is forced to 0 while rst_n=0.
  - Reset mid-burst discards the lock and any pending write.
- Winner selection (combinational, each cycle):
  - Hold case: if locked=1, req[owner]=1 and hold_cnt < MAX_HOLD, the winner is owner.
  - Otherwise: the winner is the first i with req[i]=1, scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - If no req bit is set, there is no winner and gnt=0.
  - gnt[winner]=1; all other gnt bits are 0. Never more than one bit is set.
- Edge update with a winner w:
  - q <= wdata[w]; q_upd <= 1; q_src <= w.
  - ptr <= (w+1) mod NUM_REQ. The last winner becomes lowest priority.
  - owner <= w; locked <= lock[w].
  - hold_cnt <= hold_cnt+1 if the hold case applied; otherwise hold_cnt <= 1 (start of a new burst or a single grant).
- Edge update with no winner: q holds; q_upd <= 0; locked <= 0; hold_cnt <= 0; ptr, owner and q_src hold.
- Lock release conditions:
  - The owner drops req: it is not granted; arbitration resumes from ptr the same cycle.
  - The owner drops lock while still requesting: it gets that grant, then locked=0.
  - hold_cnt reaches MAX_HOLD: the next selection is normal round-robin from ptr=owner+1, so other requesters win first.
  - If the owner is the sole requester, it wins and starts a new burst with hold_cnt=1.
- A non-owner's lock bit has no effect until that requester wins.
- Latency: grant in the same cycle as req; q, q_upd and q_src are visible one cycle after the grant.
- Sustained back-to-back writes: q_upd stays 1.
- Fairness: with all req=1 and lock=0, each requester is granted exactly once every NUM_REQ cycles.
- Pointer wrap: NUM_REQ-1 wins -> ptr=0.
- MAX_HOLD=1: lock never extends ownership.
- wdata of non-granted requesters is ignored.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with req=4'b1111 -> gnt=0, q=RST_VAL, q_upd=0; release -> first gnt=4'b0001.
- Fair rotation: req=4'b1111, lock=0, wdata[i]=0x10+i for 8 cycles -> gnt sequence 0001,0010,0100,1000 repeated; q sequence 0x10,0x11,0x12,0x13,... one cycle behind gnt; q_src=0,1,2,3.
- Burst hold/expiry: req=4'b0011, lock[0]=1, MAX_HOLD=4, after reset -> gnt[0] for 4 cycles, then gnt[1] for 1 cycle, then gnt[0] again (new burst).
- Early release: requester 2 holds with lock[2]=1; drop req[2] at the 2nd grant cycle with req[3]=1 -> gnt=4'b1000 in that same cycle.
- Sparse/wrap: only req[3] pulsed one cycle, then idle 3 cycles, then req=4'b1001 -> grants go to 3, then 0; q_upd=0 during idle; q holds the last value.
- Reset mid-burst: assert rst_n=0 while requester 1 is locked with hold_cnt=2 -> next cycle q=RST_VAL, ptr=0; after release with req=4'b0011 -> gnt=4'b0001.

Source files
------------

// File: rtl/dl_reg_rr_arb_if.sv
// Write-port bundle for the shared round-robin register.
// The master side holds the requesters; the slave side is the arbiter and its register.
interface dl_reg_rr_arb_if #(
   parameter int NUM_REQ  = 4,
   parameter int NUM_BITS = 32
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]          req;
   logic [NUM_REQ-1:0]          lock;
   logic [NUM_REQ*NUM_BITS-1:0] wdata;
   logic [NUM_REQ-1:0]          gnt;
   logic [NUM_BITS-1:0]         q;
   logic                        q_upd;
   logic [IDX_W-1:0]            q_src;

   modport master (
      output req, lock, wdata,
      input  gnt, q, q_upd, q_src
   );

   modport slave (
      input  req, lock, wdata,
      output gnt, q, q_upd, q_src
   );
endinterface

// File: rtl/dl_reg_rr_arb.sv
// Round-robin write arbiter in front of one shared register.
// One winner per cycle writes q at the next edge. A winner that also asserts lock
// may keep the port for up to MAX_HOLD consecutive grants.
module dl_reg_rr_arb #(
   parameter int                  NUM_REQ  = 4,
   parameter int                  NUM_BITS = 32,
   parameter logic [NUM_BITS-1:0] RST_VAL  = '0,
   parameter int                  MAX_HOLD = 4
) (
   input logic             clk,
   input logic             rst_n,
   dl_reg_rr_arb_if.slave  bus
);
   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int HC_W  = $clog2(MAX_HOLD + 1);

   localparam logic [HC_W-1:0]  HOLD_MAX = HC_W'(MAX_HOLD);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   // Arbitration state
   logic [IDX_W-1:0]    ptr;
   logic [IDX_W-1:0]    owner;
   logic                locked;
   logic [HC_W-1:0]     hold_cnt;

   // Registered outputs
   logic [NUM_BITS-1:0] q_r;
   logic                q_upd_r;
   logic [IDX_W-1:0]    q_src_r;

   // Combinational selection
   logic                hold_case;
   logic                found;
   logic [IDX_W-1:0]    win;
   logic [IDX_W-1:0]    scan;
   logic [IDX_W-1:0]    ptr_nxt;
   logic [NUM_REQ-1:0]  gnt_c;

   // Select the winner: the locked owner while its burst lasts, otherwise the
   // first requester found scanning upward from ptr with wrap-around.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no path leaves it
      // unassigned; a missing default here would infer a latch.
      hold_case = locked && bus.req[owner] && (hold_cnt < HOLD_MAX);
      found     = 1'b0;
      win       = ptr;
      scan      = ptr;
      if (hold_case) begin
         found = 1'b1;
         win   = owner;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            scan = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && bus.req[scan]) begin
               found = 1'b1;
               win   = scan;
            end
         end
      end
   end

   // One-hot grant, suppressed while reset is held.
   always_comb begin
      gnt_c = '0;
      if (rst_n && found) gnt_c[win] = 1'b1;
   end

   // The winner drops to lowest priority next cycle.
   assign ptr_nxt = (win == LAST_IDX) ? '0 : win + 1'b1;

   // Capture the winner's data and advance the arbitration state.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, and reset is
      // sampled on the clock edge (synchronous), so it lives inside this block.
      if (!rst_n) begin
         q_r      <= RST_VAL;
         q_upd_r  <= 1'b0;
         q_src_r  <= '0;
         ptr      <= '0;
         owner    <= '0;
         locked   <= 1'b0;
         hold_cnt <= '0;
      end else if (found) begin
         q_r      <= bus.wdata[int'(win)*NUM_BITS +: NUM_BITS];
         q_upd_r  <= 1'b1;
         q_src_r  <= win;
         ptr      <= ptr_nxt;
         owner    <= win;
         locked   <= bus.lock[win];
         hold_cnt <= hold_case ? hold_cnt + 1'b1 : HC_W'(1);
      end else begin
         q_upd_r  <= 1'b0;
         locked   <= 1'b0;
         hold_cnt <= '0;
      end
   end

   assign bus.gnt   = gnt_c;
   assign bus.q     = q_r;
   assign bus.q_upd = q_upd_r;
   assign bus.q_src = q_src_r;
endmodule

// File: tb/tb_dl_reg_rr_arb.sv
// Self-checking bench for dl_reg_rr_arb: grants are compared in the request cycle,
// register writes are queued as expectations and compared one edge later.
module tb_dl_reg_rr_arb;
   localparam int              NUM_REQ  = 4;
   localparam int              NUM_BITS = 32;
   localparam logic [31:0]     RST_VAL  = 32'hA5A5_0000;
   localparam int              MAX_HOLD = 4;

   typedef struct packed {
      logic        upd;
      logic [31:0] q;
      logic [1:0]  src;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] last_q   = RST_VAL;
   logic [1:0]  last_src = 2'd0;
   int          n_vec    = 0;
   int          n_err    = 0;
   int          n_step   = 0;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   dl_reg_rr_arb_if #(.NUM_REQ(NUM_REQ), .NUM_BITS(NUM_BITS)) bus ();

   dl_reg_rr_arb #(
      .NUM_REQ (NUM_REQ),
      .NUM_BITS(NUM_BITS),
      .RST_VAL (RST_VAL),
      .MAX_HOLD(MAX_HOLD)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   function automatic logic [31:0] data_of(input int idx, input int stp);
      return 32'(32'h10 + idx + (stp << 8));
   endfunction

   // One clock cycle: drive inputs, check gnt before the edge, queue the expected
   // register result, then check the register after the edge.
   task automatic step(input logic rst, input logic [3:0] r, input logic [3:0] l,
                       input logic [3:0] exp_gnt, input string name);
      exp_t e;
      exp_t got;
      int   widx;
      rst_n    = rst;
      bus.req  = r;
      bus.lock = l;
      for (int i = 0; i < NUM_REQ; i++) bus.wdata[i*NUM_BITS +: NUM_BITS] = data_of(i, n_step);
      @(negedge clk);
      n_vec++;
      if (bus.gnt !== exp_gnt) begin
         n_err++;
         $display("FAIL %s step%0d gnt: got %b want %b", name, n_step, bus.gnt, exp_gnt);
      end
      if (!rst) begin
         e = '{upd: 1'b0, q: RST_VAL, src: 2'd0};
      end else if (exp_gnt == 4'b0000) begin
         e = '{upd: 1'b0, q: last_q, src: last_src};
      end else begin
         widx = 0;
         for (int i = 0; i < NUM_REQ; i++) if (exp_gnt[i]) widx = i;
         e = '{upd: 1'b1, q: data_of(widx, n_step), src: 2'(widx)};
      end
      last_q   = e.q;
      last_src = e.src;
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_vec++;
      if (bus.q_upd !== got.upd) begin
         n_err++;
         $display("FAIL %s step%0d q_upd: got %b want %b", name, n_step, bus.q_upd, got.upd);
      end
      n_vec++;
      if (bus.q !== got.q) begin
         n_err++;
         $display("FAIL %s step%0d q: got %h want %h", name, n_step, bus.q, got.q);
      end
      n_vec++;
      if (bus.q_src !== got.src) begin
         n_err++;
         $display("FAIL %s step%0d q_src: got %0d want %0d", name, n_step, bus.q_src, got.src);
      end
      n_step++;
   endtask

   task automatic apply_reset();
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, "reset");
      step(1'b0, 4'b0000, 4'b0000, 4'b0000, "reset");
   endtask

   task automatic test_reset();
      step(1'b0, 4'b1111, 4'b0000, 4'b0000, "rst_hold");
      step(1'b0, 4'b1111, 4'b0000, 4'b0000, "rst_hold");
      step(1'b1, 4'b1111, 4'b0000, 4'b0001, "rst_release");
   endtask

   task automatic test_fair_rotation();
      logic [3:0] seq [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      apply_reset();
      for (int c = 0; c < 8; c++) step(1'b1, 4'b1111, 4'b0000, seq[c % 4], "fair");
   endtask

   task automatic test_burst_expiry();
      logic [3:0] seq [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001};
      apply_reset();
      for (int c = 0; c < 7; c++) step(1'b1, 4'b0011, 4'b0001, seq[c], "burst");
   endtask

   task automatic test_early_release();
      apply_reset();
      step(1'b1, 4'b1100, 4'b0100, 4'b0100, "early_grant");
      step(1'b1, 4'b1000, 4'b0100, 4'b1000, "early_drop_req");
      step(1'b1, 4'b0100, 4'b0100, 4'b0100, "lock_again");
      step(1'b1, 4'b1100, 4'b0000, 4'b0100, "drop_lock_last");
      step(1'b1, 4'b1100, 4'b0000, 4'b1000, "after_unlock");
   endtask

   task automatic test_sparse_wrap();
      apply_reset();
      step(1'b1, 4'b1000, 4'b0000, 4'b1000, "sparse_pulse");
      for (int c = 0; c < 3; c++) step(1'b1, 4'b0000, 4'b0000, 4'b0000, "sparse_idle");
      step(1'b1, 4'b1001, 4'b0000, 4'b0001, "wrap_first");
      step(1'b1, 4'b1001, 4'b0000, 4'b1000, "wrap_second");
   endtask

   task automatic test_reset_mid_burst();
      apply_reset();
      step(1'b1, 4'b0010, 4'b0010, 4'b0010, "mid_burst");
      step(1'b1, 4'b0010, 4'b0010, 4'b0010, "mid_burst");
      step(1'b0, 4'b0010, 4'b0010, 4'b0000, "mid_reset");
      step(1'b1, 4'b0011, 4'b0000, 4'b0001, "post_reset");
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req   = '0;
      bus.lock  = '0;
      bus.wdata = '0;
      test_reset();
      test_fair_rotation();
      test_burst_expiry();
      test_early_release();
      test_sparse_wrap();
      test_reset_mid_burst();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
